aes_round_engine: RTL and testbench

// - Iterative AES cipher core that runs a 128-bit block through all NR rounds of one encryption or decryption.
// - Uses one shared round datapath: encryptRound/decryptRound for rounds 1..NR-1, plus local final-round logic.
// - Holds two round-key banks (encrypt, inverse) loaded by software; valid/ready handshake on both sides.
// - Sits between the command front-end and the output packer; replaces the single-round stage.

---
 rtl/aes_round_engine_if.sv | 40 ++++
 rtl/aes_round_engine.sv | 171 +++++++++++++++++
 tb/tb_aes_round_engine.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_engine_if.sv
// Request, result and round-key write signals of the AES round engine.
interface aes_round_engine_if #(
  parameter int TAG_W = 4
);
  logic             key_wr_en;
  logic             key_wr_bank;
  logic [3:0]       key_wr_idx;
  logic [127:0]     key_wr_data;
  logic             key_wr_err;

  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             in_en_de;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_en_de;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output key_wr_en, key_wr_bank, key_wr_idx, key_wr_data,
    input  key_wr_err,
    output in_valid, in_data, in_en_de, in_tag,
    input  in_ready,
    input  out_valid, out_data, out_en_de, out_tag,
    output out_ready
  );

  modport slave (
    input  key_wr_en, key_wr_bank, key_wr_idx, key_wr_data,
    output key_wr_err,
    input  in_valid, in_data, in_en_de, in_tag,
    output in_ready,
    output out_valid, out_data, out_en_de, out_tag,
    input  out_ready
  );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES encrypt/decrypt core; define AES_ROUND_KEY_LOCK_EN to reject key writes while busy.
// Latency: out_valid NR+1 cycles after accept; one block per NR+2 cycles at best.
// Backpressure: result held in DONE until out_ready; no new request until the cycle after the drain.
module aes_round_engine #(
  parameter int NR    = 10,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_round_engine_if.slave bus,
  output logic              busy
);
  localparam int RND_W = $clog2(NR + 1);

  localparam logic [2047:0] SBOX_P = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t             st_q, st_d;
  logic [127:0]       enc_key [NR+1];
  logic [127:0]       dec_key [NR+1];
  logic [127:0]       blk_q;
  logic [RND_W-1:0]   rnd_q;
  logic               mode_q;
  logic [TAG_W-1:0]   tag_q;
  logic               last_rnd;
  logic               accept;
  logic               wr_bad;
  logic [127:0]       key0, rkey, sr, mixed, round_out;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_P[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++)
      y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8];
    return y ^ 8'h05;
  endfunction

  // InvSubBytes reuses the forward table: inv(z) = A^-1(S(z)).
  function automatic logic [7:0] isb(input logic [7:0] x);
    return aff_inv(sb(aff_inv(x)));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  // InvMixColumns = MixColumns after folding in the {04} terms.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, u, v;
    {a0, a1, a2, a3} = c;
    u = xt(xt(a0 ^ a2));
    v = xt(xt(a1 ^ a3));
    return mix_col({a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v});
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (inv) o[127-8*(4*c+r) -: 8] = isb(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
        else     o[127-8*(4*c+r) -: 8] = sb(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = inv ? inv_mix_col(s[127-32*c -: 32]) : mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  assign bus.in_ready  = (st_q == IDLE);
  assign bus.out_valid = (st_q == DONE);
  assign busy          = (st_q != IDLE);
  assign accept        = (st_q == IDLE) && bus.in_valid;
  assign last_rnd      = (rnd_q == RND_W'(NR));

  assign key0      = bus.in_en_de ? dec_key[0] : enc_key[0];
  assign rkey      = mode_q ? dec_key[rnd_q] : enc_key[rnd_q];
  assign sr        = sub_shift(blk_q, mode_q);
  assign mixed     = mix_cols(sr, mode_q);
  assign round_out = (last_rnd ? sr : mixed) ^ rkey;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (bus.in_valid) st_d = ROUND;
      ROUND:   if (last_rnd) st_d = DONE;
      DONE:    if (bus.out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q         <= '0;
      rnd_q         <= '0;
      mode_q        <= 1'b0;
      tag_q         <= '0;
      bus.out_data  <= '0;
      bus.out_tag   <= '0;
      bus.out_en_de <= 1'b0;
    end else if (accept) begin
      blk_q  <= bus.in_data ^ key0;
      rnd_q  <= RND_W'(1);
      mode_q <= bus.in_en_de;
      tag_q  <= bus.in_tag;
    end else if (st_q == ROUND) begin
      blk_q <= round_out;
      rnd_q <= rnd_q + RND_W'(1);
      if (last_rnd) begin
        bus.out_data  <= round_out;
        bus.out_tag   <= tag_q;
        bus.out_en_de <= mode_q;
      end
    end
  end

`ifdef AES_ROUND_KEY_LOCK_EN
  assign wr_bad = (int'(bus.key_wr_idx) > NR) || busy;
`else
  assign wr_bad = (int'(bus.key_wr_idx) > NR);
`endif

  // Banks are plain registers: a write and a read of one key in the same cycle sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.key_wr_err <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        enc_key[i] <= '0;
        dec_key[i] <= '0;
      end
    end else begin
      bus.key_wr_err <= bus.key_wr_en && wr_bad;
      if (bus.key_wr_en && !wr_bad) begin
        if (bus.key_wr_bank) dec_key[bus.key_wr_idx] <= bus.key_wr_data;
        else                 enc_key[bus.key_wr_idx] <= bus.key_wr_data;
      end
    end
  end
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine against the FIPS-197 AES-128 vector.
module tb_aes_round_engine;
  localparam int NR    = 10;
  localparam int TAG_W = 4;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef AES_ROUND_KEY_LOCK_EN
  localparam logic LOCK = 1'b1;
`else
  localparam logic LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  logic [127:0] ek [NR+1];
  logic [127:0] dk [NR+1];
  logic [7:0]   sbox_t [256];

  aes_round_engine_if #(.TAG_W(TAG_W)) bus ();
  aes_round_engine #(.NR(NR), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                               gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

  // S-box from its definition (GF inverse + affine), then the AES-128 schedule.
  task automatic build_keys();
    logic [7:0]   inv, s, c;
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [127:0] k;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
    k  = KEY;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    dk[0]  = ek[NR];
    dk[NR] = ek[0];
    for (int r = 1; r < NR; r++) dk[r] = inv_mix(ek[NR-r]);
  endtask

  task automatic write_key(input logic bank, input logic [3:0] idx, input logic [127:0] d);
    bus.key_wr_en   = 1'b1;
    bus.key_wr_bank = bank;
    bus.key_wr_idx  = idx;
    bus.key_wr_data = d;
    @(negedge clk);
    bus.key_wr_en   = 1'b0;
  endtask

  task automatic load_keys();
    for (int r = 0; r <= NR; r++) begin
      write_key(1'b0, 4'(r), ek[r]);
      write_key(1'b1, 4'(r), dk[r]);
    end
  endtask

  // Called at a negedge with the engine idle; returns at the negedge where out_valid is first seen.
  task automatic run_block(input logic [127:0] d, input logic m, input logic [3:0] t,
                           output logic [127:0] od, output logic oe, output logic [3:0] ot,
                           output int lat);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_en_de = m;
    bus.in_tag   = t;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    od = bus.out_data;
    oe = bus.out_en_de;
    ot = bus.out_tag;
  endtask

  initial begin
    logic [127:0] od;
    logic         oe;
    logic [3:0]   ot;
    int           lat, n, got, acc_n, seen;
    logic         acc_b;
    logic [127:0] bd [2];
    logic [3:0]   bt [2];
    logic         be [2];
    int           bn [2];

    bus.key_wr_en = 1'b0; bus.key_wr_bank = 1'b0; bus.key_wr_idx = '0; bus.key_wr_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_en_de = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b0;
    build_keys();
    repeat (2) @(negedge clk);

    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_out_tag", 128'(bus.out_tag), '0);
    check1("rst_out_en_de", bus.out_en_de, 1'b0);
    check1("rst_key_wr_err", bus.key_wr_err, 1'b0);
    check1("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    load_keys();
    check1("load_no_err", bus.key_wr_err, 1'b0);

    write_key(1'b0, 4'd11, {128{1'b1}});
    check1("bad_idx_err", bus.key_wr_err, 1'b1);
    @(negedge clk);
    check1("bad_idx_err_pulse", bus.key_wr_err, 1'b0);

    // Encrypt FIPS vector.
    bus.out_ready = 1'b1;
    run_block(PT, 1'b0, 4'h5, od, oe, ot, lat);
    checki("enc_latency", lat, 11);
    check("enc_data", od, CT);
    check("enc_tag", 128'(ot), 128'h5);
    check1("enc_en_de", oe, 1'b0);
    check1("enc_busy_done", busy, 1'b1);
    check1("enc_in_ready_done", bus.in_ready, 1'b0);
    @(negedge clk);
    check1("enc_drained", bus.out_valid, 1'b0);
    check1("enc_in_ready_back", bus.in_ready, 1'b1);
    check("enc_data_kept", bus.out_data, CT);

    // Decrypt back.
    run_block(CT, 1'b1, 4'ha, od, oe, ot, lat);
    checki("dec_latency", lat, 11);
    check("dec_data", od, PT);
    check("dec_tag", 128'(ot), 128'ha);
    check1("dec_en_de", oe, 1'b1);
    @(negedge clk);

    // Output backpressure for 5 cycles.
    bus.out_ready = 1'b0;
    run_block(PT, 1'b0, 4'h7, od, oe, ot, lat);
    check("stall_data0", od, CT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("stall_valid", bus.out_valid, 1'b1);
      check("stall_data", bus.out_data, CT);
      check("stall_tag", 128'(bus.out_tag), 128'h7);
      check1("stall_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check1("stall_drain_valid", bus.out_valid, 1'b0);
    check1("stall_drain_in_ready", bus.in_ready, 1'b1);

    // Back-to-back with in_valid held: tag 3 encrypts, tag 9 decrypts.
    check1("b2b_ready0", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = PT; bus.in_en_de = 1'b0; bus.in_tag = 4'h3;
    @(negedge clk);
    bus.in_data = CT; bus.in_en_de = 1'b1; bus.in_tag = 4'h9;
    n = 0; got = 0; acc_n = 0; acc_b = 1'b0;
    while (got < 2 && n < 80) begin
      @(negedge clk);
      n++;
      if (acc_b) bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        bd[got] = bus.out_data; bt[got] = bus.out_tag; be[got] = bus.out_en_de; bn[got] = n;
        if (got == 0) check1("b2b_no_accept_in_drain", bus.in_ready, 1'b0);
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_b = 1'b1;
        acc_n = n;
      end
    end
    bus.in_valid = 1'b0;
    checki("b2b_count", got, 2);
    checki("b2b_first_cycle", bn[0], 10);
    checki("b2b_second_accept", acc_n, 11);
    checki("b2b_second_cycle", bn[1], 22);
    check("b2b_tag0", 128'(bt[0]), 128'h3);
    check("b2b_data0", bd[0], CT);
    check1("b2b_mode0", be[0], 1'b0);
    check("b2b_tag1", 128'(bt[1]), 128'h9);
    check("b2b_data1", bd[1], PT);
    check1("b2b_mode1", be[1], 1'b1);
    @(negedge clk);

    // Key 0 overwritten in the accept cycle: this block still uses the old key 0.
    bus.key_wr_en = 1'b1; bus.key_wr_bank = 1'b0; bus.key_wr_idx = 4'd0; bus.key_wr_data = '0;
    run_block(PT, 1'b0, 4'h1, od, oe, ot, lat);
    check("acc_wr_old_key0", od, CT);
    check1("acc_wr_no_err", bus.key_wr_err, 1'b0);
    @(negedge clk);
    run_block(PT, 1'b0, 4'h2, od, oe, ot, lat);
    checks++;
    assert (od !== CT) else begin
      errors++;
      $error("FAIL acc_wr_landed: observed %h expected anything but %h", od, CT);
    end
    @(negedge clk);
    write_key(1'b0, 4'd0, ek[0]);

    // Key write while a block is in its rounds.
    bus.in_valid = 1'b1; bus.in_data = PT; bus.in_en_de = 1'b0; bus.in_tag = 4'h4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    write_key(1'b0, 4'd5, '0);
    check1("busy_wr_err", bus.key_wr_err, LOCK);
    lat = 2;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checki("busy_wr_latency", lat, 11);
`ifdef AES_ROUND_KEY_LOCK_EN
    check("busy_wr_locked_data", bus.out_data, CT);
`else
    checks++;
    assert (bus.out_data !== CT) else begin
      errors++;
      $error("FAIL busy_wr_applied: observed %h expected anything but %h", bus.out_data, CT);
    end
`endif
    @(negedge clk);
    write_key(1'b0, 4'd5, ek[5]);

    // Reset in the middle of a block.
    bus.in_valid = 1'b1; bus.in_data = PT; bus.in_en_de = 1'b0; bus.in_tag = 4'hc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check1("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("mid_rst_in_ready", bus.in_ready, 1'b1);
    check1("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_out_data", bus.out_data, '0);
    check("mid_rst_out_tag", 128'(bus.out_tag), '0);
    check1("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checki("mid_rst_nothing_emitted", seen, 0);
    load_keys();
    run_block(PT, 1'b0, 4'hd, od, oe, ot, lat);
    checki("post_rst_latency", lat, 11);
    check("post_rst_data", od, CT);
    check("post_rst_tag", 128'(ot), 128'hd);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
